sram_readback_checker: RTL and testbench
========================================

Name: sram_readback_checker

Overview:
Downstream stage of the SRAM fill controller. Once the fill sequence has completed, it is pulsed with start. It then reads every SRAM location in order and compares each word against the expected incrementing pattern. It reports mismatch count, first failing address and a pass flag. It shares the SRAM control bus (address, CS, OE, WE) and drives it only while busy.

Parameters:
AW, 5, address width
DW, 8, data width
DEPTH, 32, number of locations scanned (addresses 0..DEPTH-1, DEPTH <= 2^AW)
RD_WAIT, 1, wait cycles between OE assertion and data sample (0 allowed)
SEED, 1, expected data at address 0; expected(a) = (SEED + a) mod 2^DW

Ports:
clk  in  1  clock, rising edge
reset  in  1  asynchronous, active-high
start  in  1  begin scan; sampled only in IDLE
sram_addr  out  AW  SRAM address
sram_cs  out  1  chip select, active-high
sram_oe  out  1  output enable (read), active-high
sram_we  out  1  write enable, active-high; constant 0
sram_rdata  in  DW  SRAM read data
busy  out  1  high from start acceptance until the FINISH cycle, inclusive
done  out  1  one-cycle pulse at scan end
pass  out  1  1 when the last scan had zero mismatches
err_count  out  AW+1  mismatches in the last scan, saturating at DEPTH
first_err_valid  out  1  at least one mismatch in the last scan
first_err_addr  out  AW  lowest mismatching address; valid when first_err_valid=1

Behaviour:
- Interface: reset is asynchronous, active-high; clock is clk.
- All outputs are registered.
- Reset values: sram_addr=0, sram_cs=0, sram_oe=0, sram_we=0, busy=0, done=0, pass=0, err_count=0, first_err_valid=0, first_err_addr=0, FSM=IDLE, wait counter=0.
- States: IDLE, SETUP, WAIT, SAMPLE, FINISH.
- IDLE:
  - cs=oe=0.
  - start=1 -> SETUP. On this edge: sram_addr=0, err_count=0, first_err_valid=0, first_err_addr=0, pass=0, busy=1.
  - start=0 -> stay.
- SETUP:
  - cs=1, oe=1, address stable.
  - RD_WAIT>0 -> WAIT and load wait counter with RD_WAIT-1.
  - RD_WAIT=0 -> SAMPLE.
- WAIT:
  - cs=oe=1.
  - Counter decrements each cycle.
  - Counter==0 -> SAMPLE.
- SAMPLE:
  - cs=oe=1; sram_rdata compared with expected(sram_addr) this cycle.
  - On mismatch: err_count increments, saturating at DEPTH. If first_err_valid=0, then first_err_addr=sram_addr and first_err_valid=1.
  - sram_addr != DEPTH-1: sram_addr increments -> SETUP.
  - sram_addr == DEPTH-1: -> FINISH; address held, no wrap.
- FINISH:
  - cs=oe=0, done=1 for exactly this cycle.
  - pass=(final err_count==0), including the last SAMPLE result.
  - -> IDLE; busy drops on the edge leaving FINISH.
- Latency: each location takes RD_WAIT+2 cycles. done is asserted DEPTH*(RD_WAIT+2)+1 cycles after the start-accept edge (97 cycles for the defaults).
- Expected-value arithmetic: computed DW-bit wide, wraps mod 2^DW. Address-to-data extension is zero-extend.
- start while busy: ignored. No restart, no effect on results.
- start held high continuously: a new scan begins on the cycle after FINISH; results are cleared again.
- Results (pass, err_count, first_err_*): held stable in IDLE until the next accepted start.
- sram_rdata: don't-care outside SAMPLE; X outside SAMPLE must not propagate to results.
- Reset mid-scan:
  - cs/oe fall asynchronously, FSM returns to IDLE, all results clear.
  - No done pulse is produced.
  - The next start rescans from address 0.
- sram_we is never asserted in any state.

Test Plan:
1. Memory model holds SEED+a at every address; start pulsed 1 cycle -> exactly 32 SAMPLE cycles, done at cycle 97, pass=1, err_count=0, first_err_valid=0.
2. Location 7 corrupted to 0x00 (expected 0x08) -> err_count=1, first_err_valid=1, first_err_addr=7, pass=0.
3. All locations 0xFF (address 31 expects 0x20) -> err_count=32 (saturation reached, no overflow), first_err_addr=0, pass=0.
4. start re-pulsed at cycles 10 and 50 of a scan -> ignored; single done pulse; results identical to test 1.
5. reset asserted while sram_addr=12 in WAIT -> cs/oe/busy low before the next clk edge, results 0, no done; later start -> full scan from address 0, pass=1.
6. RD_WAIT=0 and RD_WAIT=3 builds with a model whose data becomes valid RD_WAIT cycles after OE -> done at cycles 65 and 161 respectively, pass=1; sram_we observed 0 throughout.

Source files
------------

// File: rtl/sram_readback_checker.sv
// Scans SRAM addresses 0..DEPTH-1 after a start pulse and checks that each
// word equals the incrementing pattern (SEED + addr) mod 2^DW.
// Ports:
//   clk, reset          clock (rising edge), asynchronous active-high reset
//   start               begin a scan; only looked at while idle
//   sram_addr/cs/oe/we  SRAM control bus, driven active only while busy
//   sram_rdata          SRAM read data, sampled in the SAMPLE state only
//   busy, done          scan in progress / one-cycle end-of-scan pulse
//   pass, err_count,
//   first_err_valid,
//   first_err_addr      results of the last scan, held until the next start
module sram_readback_checker #(
  parameter int unsigned AW      = 5,
  parameter int unsigned DW      = 8,
  parameter int unsigned DEPTH   = 32,
  parameter int unsigned RD_WAIT = 1,
  parameter int unsigned SEED    = 1
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          start,
  output logic [AW-1:0] sram_addr,
  output logic          sram_cs,
  output logic          sram_oe,
  output logic          sram_we,
  input  logic [DW-1:0] sram_rdata,
  output logic          busy,
  output logic          done,
  output logic          pass,
  output logic [AW:0]   err_count,
  output logic          first_err_valid,
  output logic [AW-1:0] first_err_addr
);

  // Wait counter only needs to hold RD_WAIT-1.
  localparam int unsigned CW = (RD_WAIT > 1) ? $clog2(RD_WAIT) : 1;
  localparam logic [CW-1:0] WAIT_LOAD = CW'((RD_WAIT > 0) ? (RD_WAIT - 1) : 0);
  localparam logic [AW-1:0] LAST_ADDR = AW'(DEPTH - 1);
  localparam logic [AW:0]   ERR_MAX   = (AW+1)'(DEPTH);
  localparam logic [DW-1:0] SEED_W    = DW'(SEED);

  typedef enum logic [2:0] {
    S_IDLE,
    S_SETUP,
    S_WAIT,
    S_SAMPLE,
    S_FINISH
  } state_t;

  state_t        state;
  logic [CW-1:0] wait_cnt;

  logic [DW-1:0] expected_c;
  logic          mismatch_c;
  logic [AW:0]   err_next_c;

  // Compare against the pattern word; result is only consumed in SAMPLE.
  always_comb begin
    expected_c = SEED_W + DW'(sram_addr);
    mismatch_c = (sram_rdata != expected_c);
    err_next_c = err_count;
    if (mismatch_c && (err_count != ERR_MAX)) begin
      err_next_c = err_count + (AW+1)'(1);
    end
  end

  // Scan FSM with registered bus controls and results.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state           <= S_IDLE;
      wait_cnt        <= '0;
      sram_addr       <= '0;
      sram_cs         <= 1'b0;
      sram_oe         <= 1'b0;
      sram_we         <= 1'b0;
      busy            <= 1'b0;
      done            <= 1'b0;
      pass            <= 1'b0;
      err_count       <= '0;
      first_err_valid <= 1'b0;
      first_err_addr  <= '0;
    end else begin
      done    <= 1'b0;
      sram_we <= 1'b0;
      case (state)
        S_IDLE: begin
          if (start) begin
            state           <= S_SETUP;
            sram_addr       <= '0;
            err_count       <= '0;
            first_err_valid <= 1'b0;
            first_err_addr  <= '0;
            pass            <= 1'b0;
            busy            <= 1'b1;
            sram_cs         <= 1'b1;
            sram_oe         <= 1'b1;
          end
        end
        S_SETUP: begin
          if (RD_WAIT > 0) begin
            state    <= S_WAIT;
            wait_cnt <= WAIT_LOAD;
          end else begin
            state <= S_SAMPLE;
          end
        end
        S_WAIT: begin
          if (wait_cnt == '0) begin
            state <= S_SAMPLE;
          end else begin
            wait_cnt <= wait_cnt - CW'(1);
          end
        end
        S_SAMPLE: begin
          err_count <= err_next_c;
          if (mismatch_c && !first_err_valid) begin
            first_err_valid <= 1'b1;
            first_err_addr  <= sram_addr;
          end
          // Last location: drop the bus and report; address is held, not wrapped.
          if (sram_addr == LAST_ADDR) begin
            state   <= S_FINISH;
            sram_cs <= 1'b0;
            sram_oe <= 1'b0;
            done    <= 1'b1;
            pass    <= (err_next_c == '0);
          end else begin
            sram_addr <= sram_addr + AW'(1);
            state     <= S_SETUP;
          end
        end
        S_FINISH: begin
          state <= S_IDLE;
          busy  <= 1'b0;
        end
        default: begin
          state <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_sram_readback_checker.sv
// Bench for sram_readback_checker: three instances (RD_WAIT = 1, 0, 3) share
// one memory image; each has a slow-read SRAM model and a done-driven monitor
// that pops expected results queued by the stimulus process.
module tb_sram_readback_checker;

  localparam int AW    = 5;
  localparam int DW    = 8;
  localparam int DEPTH = 32;
  localparam int SEED  = 1;
  localparam int N     = 3;

  typedef struct {
    int errs;
    int fev;
    int fea;
    int pass;
    int lat;
  } exp_t;

  logic clk = 1'b0;
  logic reset;
  logic start;

  logic [DW-1:0] mem [DEPTH];

  logic [AW-1:0] sram_addr       [N];
  logic          sram_cs         [N];
  logic          sram_oe         [N];
  logic          sram_we         [N];
  logic [DW-1:0] sram_rdata      [N];
  logic          busy            [N];
  logic          done            [N];
  logic          pass            [N];
  logic [AW:0]   err_count       [N];
  logic          first_err_valid [N];
  logic [AW-1:0] first_err_addr  [N];

  exp_t expq [N][$];
  exp_t last_exp;
  int   vectors     = 0;
  int   miscompares = 0;
  int   cyc         = 0;
  bit   we_seen     = 1'b0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  function automatic int rdw(input int i);
    return (i == 0) ? 1 : ((i == 1) ? 0 : 3);
  endfunction

  task automatic chk(input string name, input int act, input int expv);
    vectors++;
    if (act != expv) begin
      miscompares++;
      $display("FAIL %s: got %0d, expected %0d", name, act, expv);
    end
  endtask

  for (genvar i = 0; i < N; i++) begin : g
    localparam int W = (i == 0) ? 1 : ((i == 1) ? 0 : 3);

    sram_readback_checker #(
      .AW(AW), .DW(DW), .DEPTH(DEPTH), .RD_WAIT(W), .SEED(SEED)
    ) dut (
      .clk(clk),
      .reset(reset),
      .start(start),
      .sram_addr(sram_addr[i]),
      .sram_cs(sram_cs[i]),
      .sram_oe(sram_oe[i]),
      .sram_we(sram_we[i]),
      .sram_rdata(sram_rdata[i]),
      .busy(busy[i]),
      .done(done[i]),
      .pass(pass[i]),
      .err_count(err_count[i]),
      .first_err_valid(first_err_valid[i]),
      .first_err_addr(first_err_addr[i])
    );

    // SRAM model: data is garbage until the address has been stable with OE
    // high for W+1 cycles, i.e. it only becomes correct in the sample cycle.
    int            age       = 0;
    logic [AW-1:0] last_addr = '0;
    logic          last_oe   = 1'b0;
    always @(posedge clk) begin
      #1;
      if (!sram_oe[i] || !last_oe || (sram_addr[i] != last_addr)) age = 0;
      else age++;
      last_addr = sram_addr[i];
      last_oe   = sram_oe[i];
      sram_rdata[i] = (sram_oe[i] && (age >= W + 1)) ? mem[sram_addr[i]] : 8'($urandom);
      if (sram_we[i]) we_seen = 1'b1;
    end

    // Monitor: latency measured from the edge where busy first rises.
    logic prev_busy = 1'b0;
    int   t0        = 0;
    always @(posedge clk) begin
      exp_t e;
      #1;
      if (reset) begin
        prev_busy = 1'b0;
      end else begin
        if (busy[i] && !prev_busy) t0 = cyc;
        prev_busy = busy[i];
        if (done[i]) begin
          if (expq[i].size() == 0) begin
            chk($sformatf("unexpected_done[w%0d]", W), 1, 0);
          end else begin
            e = expq[i].pop_front();
            chk($sformatf("err_count[w%0d]", W), int'(err_count[i]), e.errs);
            chk($sformatf("first_err_valid[w%0d]", W), int'(first_err_valid[i]), e.fev);
            chk($sformatf("first_err_addr[w%0d]", W), int'(first_err_addr[i]), e.fea);
            chk($sformatf("pass[w%0d]", W), int'(pass[i]), e.pass);
            chk($sformatf("done_latency[w%0d]", W), cyc - t0 + 1, e.lat);
            chk($sformatf("finish_cs_oe[w%0d]", W), int'({sram_cs[i], sram_oe[i]}), 0);
            chk($sformatf("finish_busy[w%0d]", W), int'(busy[i]), 1);
            chk($sformatf("finish_addr[w%0d]", W), int'(sram_addr[i]), DEPTH - 1);
          end
        end
      end
    end
  end

  task automatic fill_good();
    for (int a = 0; a < DEPTH; a++) mem[a] = 8'(SEED + a);
  endtask

  // Reference results straight from the pattern definition.
  task automatic push_all();
    int   errs  = 0;
    int   first = -1;
    exp_t e;
    for (int a = 0; a < DEPTH; a++) begin
      if (mem[a] != 8'(SEED + a)) begin
        errs++;
        if (first < 0) first = a;
      end
    end
    e.errs = (errs > DEPTH) ? DEPTH : errs;
    e.fev  = (errs > 0) ? 1 : 0;
    e.fea  = (first < 0) ? 0 : first;
    e.pass = (errs == 0) ? 1 : 0;
    for (int i = 0; i < N; i++) begin
      e.lat = DEPTH * (rdw(i) + 2) + 1;
      expq[i].push_back(e);
      if (i == 0) last_exp = e;
    end
  endtask

  task automatic pulse_start();
    @(negedge clk) start = 1'b1;
    @(negedge clk) start = 1'b0;
  endtask

  task automatic wait_drain();
    int n = 0;
    while ((expq[0].size() + expq[1].size() + expq[2].size()) != 0 && n < 1000) begin
      @(negedge clk);
      n++;
    end
    if (n >= 1000) begin
      chk("drain_timeout", 1, 0);
      for (int i = 0; i < N; i++) expq[i].delete();
    end
    repeat (3) @(negedge clk);
  endtask

  // Results must stay put in IDLE after the scan.
  task automatic check_hold(input string tag);
    chk({tag, "_hold_err"}, int'(err_count[0]), last_exp.errs);
    chk({tag, "_hold_fev"}, int'(first_err_valid[0]), last_exp.fev);
    chk({tag, "_hold_fea"}, int'(first_err_addr[0]), last_exp.fea);
    chk({tag, "_hold_pass"}, int'(pass[0]), last_exp.pass);
    chk({tag, "_hold_busy"}, int'(busy[0]), 0);
  endtask

  task automatic run_scan(input string tag);
    push_all();
    pulse_start();
    wait_drain();
    check_hold(tag);
  endtask

  task automatic check_cleared(input string tag);
    chk({tag, "_addr"}, int'(sram_addr[0]), 0);
    chk({tag, "_cs"}, int'(sram_cs[0]), 0);
    chk({tag, "_oe"}, int'(sram_oe[0]), 0);
    chk({tag, "_busy"}, int'(busy[0]), 0);
    chk({tag, "_done"}, int'(done[0]), 0);
    chk({tag, "_pass"}, int'(pass[0]), 0);
    chk({tag, "_err"}, int'(err_count[0]), 0);
    chk({tag, "_fev"}, int'(first_err_valid[0]), 0);
    chk({tag, "_fea"}, int'(first_err_addr[0]), 0);
  endtask

  initial begin
    #500000;
    $display("FAIL global_timeout: got no end, expected finish");
    $fatal(1);
  end

  initial begin
    reset = 1'b1;
    start = 1'b0;
    fill_good();
    repeat (2) @(negedge clk);
    check_cleared("reset");
    chk("reset_we", int'(sram_we[0]), 0);
    @(negedge clk) reset = 1'b0;
    repeat (2) @(negedge clk);

    // Clean memory.
    run_scan("clean");

    // Single corruption at address 7.
    fill_good();
    mem[7] = 8'h00;
    run_scan("addr7");

    // Every word 0xFF: all 32 locations mismatch.
    for (int a = 0; a < DEPTH; a++) mem[a] = 8'hFF;
    run_scan("all_ff");

    // Start re-pulsed mid-scan must be ignored.
    fill_good();
    push_all();
    pulse_start();
    repeat (8) @(negedge clk);
    start = 1'b1;
    @(negedge clk) start = 1'b0;
    repeat (39) @(negedge clk);
    start = 1'b1;
    @(negedge clk) start = 1'b0;
    wait_drain();
    check_hold("restart");

    // Reset in the wait state of address 12; no done may follow.
    fill_good();
    mem[3] = 8'h55;
    @(negedge clk) start = 1'b1;
    @(posedge clk);
    @(negedge clk) start = 1'b0;
    repeat (37) @(posedge clk);
    #2;
    chk("prereset_addr", int'(sram_addr[0]), 12);
    chk("prereset_cs", int'(sram_cs[0]), 1);
    chk("prereset_err", int'(err_count[0]), 1);
    reset = 1'b1;
    #1;
    check_cleared("midreset");
    @(negedge clk) reset = 1'b0;
    repeat (120) @(negedge clk);
    fill_good();
    run_scan("after_reset");

    // Randomized corruptions.
    for (int r = 0; r < 6; r++) begin
      fill_good();
      if (r == 5) begin
        for (int a = 0; a < DEPTH; a++) mem[a] = 8'($urandom);
      end else begin
        int k = $urandom_range(0, 5);
        for (int j = 0; j < k; j++) begin
          int a = $urandom_range(0, DEPTH - 1);
          mem[a] = mem[a] ^ 8'($urandom_range(1, 255));
        end
      end
      run_scan($sformatf("rand%0d", r));
    end

    chk("sram_we_never", int'(we_seen), 0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
